// File: rtl/inv_key_expansion_if.sv
// inv_key_expansion_if: load/step control and round-key outputs of the inverse AES-128 key schedule
interface inv_key_expansion_if;
  logic         load_i;
  logic [127:0] last_key_i;
  logic         step_i;
  logic [127:0] round_key_o;
  logic [3:0]   round_o;
  logic         valid_o;
  logic         done_o;
  modport master (output load_i, last_key_i, step_i, input round_key_o, round_o, valid_o, done_o);
  modport slave  (input load_i, last_key_i, step_i, output round_key_o, round_o, valid_o, done_o);
endinterface

// File: rtl/inv_key_expansion.sv
// inv_key_expansion: byte-serial AES-128 inverse key schedule, one shared S-box, 6 cycles per round key
module inv_key_expansion #(
  parameter int NR = 10
) (
  input logic clk,
  input logic rst,
  inv_key_expansion_if.slave bus
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;
  typedef enum logic [1:0] {IDLE, READY, CALC} state_t;
  state_t state, state_nxt;
  logic [127:0] key;
  logic [3:0] round;
  logic [2:0] cnt;
  logic [0:3][7:0] sub, t;
  logic valid, accept;
  logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3;
  logic [7:0] sbox_out;
  assign {w0, w1, w2, w3} = key;
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign t = {p3[23:0], p3[31:24]};
  // Rcon is folded into sub[0] at cnt 4, so sub already holds SubWord(t) ^ {Rcon, 24'h0}
  assign p0 = w0 ^ sub;
  assign sbox_out = SBOX[t[cnt[1:0]]];
  assign accept = state == READY && bus.step_i && round != 4'd0;
  always_comb begin
    state_nxt = state;
    state_nxt = bus.load_i ? READY :
                accept ? CALC :
                (state == CALC && cnt == 3'd5) ? READY : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      key <= '0;
      round <= '0;
      cnt <= '0;
      sub <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus.load_i) begin
        key <= bus.last_key_i;
        round <= 4'(NR);
        cnt <= '0;
        valid <= 1'b1;
      end else if (accept) begin
        cnt <= '0;
        valid <= 1'b0;
      end else if (state == CALC) begin
        if (cnt < 3'd4) begin
          sub[cnt[1:0]] <= sbox_out;
          cnt <= cnt + 3'd1;
        end else if (cnt == 3'd4) begin
          sub[0] <= sub[0] ^ RCON[round - 4'd1];
          cnt <= cnt + 3'd1;
        end else begin
          key <= {p0, p1, p2, p3};
          round <= round - 4'd1;
          valid <= 1'b1;
          cnt <= '0;
        end
      end
    end
  assign bus.round_key_o = key;
  assign bus.round_o = round;
  assign bus.valid_o = valid;
  assign bus.done_o = valid && round == 4'd0;
endmodule

// File: tb/tb_inv_key_expansion.sv
// tb_inv_key_expansion: directed checks of the inverse key schedule against FIPS-197 round keys
module tb_inv_key_expansion;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  inv_key_expansion_if bus();
  inv_key_expansion dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KX  = 128'h00112233445566778899aabbccddeeff;
  typedef struct {
    logic [3:0]   round;
    logic         chk_key;
    logic [127:0] key;
  } vec_t;
  vec_t vecs[10];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask
  task automatic chk_state(input string name, input logic [3:0] r, input logic v, input logic [127:0] k);
    chk({name, ".round"}, 128'(bus.round_o), 128'(r));
    chk({name, ".valid"}, 128'(bus.valid_o), 128'(v));
    chk({name, ".key"}, bus.round_key_o, k);
  endtask
  task automatic do_load(input logic [127:0] k);
    bus.load_i = 1'b1;
    bus.last_key_i = k;
    tick();
    bus.load_i = 1'b0;
  endtask
  task automatic pulse_step();
    bus.step_i = 1'b1;
    tick();
    bus.step_i = 1'b0;
  endtask
  initial begin
    vecs[0] = '{4'd9, 1'b1, K9};
    vecs[1] = '{4'd8, 1'b0, '0};
    vecs[2] = '{4'd7, 1'b0, '0};
    vecs[3] = '{4'd6, 1'b0, '0};
    vecs[4] = '{4'd5, 1'b0, '0};
    vecs[5] = '{4'd4, 1'b0, '0};
    vecs[6] = '{4'd3, 1'b0, '0};
    vecs[7] = '{4'd2, 1'b0, '0};
    vecs[8] = '{4'd1, 1'b1, K1};
    vecs[9] = '{4'd0, 1'b1, K0};
    bus.load_i = 1'b0;
    bus.step_i = 1'b0;
    bus.last_key_i = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_state("reset", 4'd0, 1'b0, '0);
    chk("reset.done", 128'(bus.done_o), 128'd0);
    pulse_step();
    repeat (7) tick();
    chk_state("idle_step", 4'd0, 1'b0, '0);
    do_load(K10);
    chk_state("load", 4'd10, 1'b1, K10);
    chk("load.done", 128'(bus.done_o), 128'd0);
    for (int i = 0; i < 10; i++) begin
      pulse_step();
      for (int c = 0; c < 6; c++) begin
        chk($sformatf("step%0d.calc%0d.valid", i, c), 128'(bus.valid_o), 128'd0);
        chk($sformatf("step%0d.calc%0d.round", i, c), 128'(bus.round_o), 128'(vecs[i].round + 4'd1));
        if (i == 0) chk($sformatf("step0.calc%0d.key", c), bus.round_key_o, K10);
        tick();
      end
      chk($sformatf("step%0d.valid", i), 128'(bus.valid_o), 128'd1);
      chk($sformatf("step%0d.round", i), 128'(bus.round_o), 128'(vecs[i].round));
      if (vecs[i].chk_key) chk($sformatf("step%0d.key", i), bus.round_key_o, vecs[i].key);
    end
    chk("round0.done", 128'(bus.done_o), 128'd1);
    pulse_step();
    chk_state("r0_step_now", 4'd0, 1'b1, K0);
    repeat (7) tick();
    chk_state("r0_step_later", 4'd0, 1'b1, K0);
    chk("r0_step.done", 128'(bus.done_o), 128'd1);
    do_load(K10);
    pulse_step();
    tick();
    tick();
    pulse_step();
    tick();
    tick();
    tick();
    chk_state("calc_step", 4'd9, 1'b1, K9);
    repeat (7) tick();
    chk_state("calc_step_later", 4'd9, 1'b1, K9);
    pulse_step();
    tick();
    tick();
    do_load(KX);
    chk_state("load_in_calc", 4'd10, 1'b1, KX);
    repeat (7) tick();
    chk_state("load_in_calc_later", 4'd10, 1'b1, KX);
    bus.step_i = 1'b1;
    do_load(K10);
    bus.step_i = 1'b0;
    chk_state("load_and_step", 4'd10, 1'b1, K10);
    repeat (7) tick();
    chk_state("load_and_step_later", 4'd10, 1'b1, K10);
    pulse_step();
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk_state("async_rst", 4'd0, 1'b0, '0);
    tick();
    rst = 1'b0;
    pulse_step();
    repeat (7) tick();
    chk_state("post_rst_step", 4'd0, 1'b0, '0);
    do_load(K10);
    chk_state("post_rst_load", 4'd10, 1'b1, K10);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
